// File: rtl/reg_bank_pkg.sv
// Shared widths, flag bit positions and the pending write-stage record
// for the architectural register bank.
package reg_bank_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  // One-deep writeback stage sitting between the shifter and the array
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [WIDTH-1:0] data;
  } pend_t;

endpackage

// File: rtl/reg_bank_flags.sv
// Z/N/C status flag register, loaded from the writeback result when
// flag_en is high and held otherwise.
module reg_bank_flags
  import reg_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_en,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  output logic [2:0]       flags
);

  // Capture status from the current result; compare-style ops with no
  // destination still update flags here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_en) begin
      flags[FLAG_Z] <= (result == '0);
      flags[FLAG_N] <= result[WIDTH-1];
      flags[FLAG_C] <= carry;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank with a one-deep write pipeline stage, two
// combinational read ports and Z/N/C flags.
// Optional feature: define REG_BANK_BYPASS_EN to forward the pending
// write to the read ports (read-after-write latency of one cycle).
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sh_out,
  input  logic             alu_c,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flag_en,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_out,
  output logic [WIDTH-1:0] rb_out,
  output logic [2:0]       flags,
  output logic             wb_busy
);

  pend_t            pend;
  logic [WIDTH-1:0] regs [NREGS];

  // Pending stage: writes to R0 are dropped here so they never commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend.valid <= wr_en && (wr_addr != '0);
      pend.addr  <= wr_addr;
      pend.data  <= sh_out;
    end
  end

  // Commit the pending write; reset drops it rather than committing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (pend.valid) begin
      regs[pend.addr] <= pend.data;
    end
  end

  // Read muxes; R0 reads zero, optional forwarding from the pending stage.
  always_comb begin
    ra_out = (ra_addr == '0) ? '0 : regs[ra_addr];
    rb_out = (rb_addr == '0) ? '0 : regs[rb_addr];
`ifdef REG_BANK_BYPASS_EN
    if (pend.valid && (pend.addr == ra_addr) && (ra_addr != '0)) ra_out = pend.data;
    if (pend.valid && (pend.addr == rb_addr) && (rb_addr != '0)) rb_out = pend.data;
`else
`endif
  end

  assign wb_busy = pend.valid;

  reg_bank_flags u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag_en (flag_en),
    .result  (sh_out),
    .carry   (alu_c),
    .flags   (flags)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: expected outputs are computed from a
// behavioural model when stimulus is applied and compared at the negedge.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] sh_out;
  logic        alu_c;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic        flag_en;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_out;
  logic [15:0] rb_out;
  logic [2:0]  flags;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  fl;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model state
  logic [15:0] m_arr [8];
  logic        m_pv;
  logic [2:0]  m_pa;
  logic [15:0] m_pd;
  logic [2:0]  m_fl;

  reg_bank dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sh_out  (sh_out),
    .alu_c   (alu_c),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .flag_en (flag_en),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_out  (ra_out),
    .rb_out  (rb_out),
    .flags   (flags),
    .wb_busy (wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
`ifdef REG_BANK_BYPASS_EN
    if (m_pv && m_pa == a) return m_pd;
`endif
    return m_arr[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_arr[i] = 16'h0000;
    m_pv = 1'b0;
    m_pa = 3'd0;
    m_pd = 16'h0000;
    m_fl = 3'b000;
  endtask

  // Called at posedge+1 with inputs already applied: push expectation,
  // compare at negedge, then advance the model across the next posedge.
  task automatic step();
    exp_t e;
    exp_t got;
    e.ra   = model_read(ra_addr);
    e.rb   = model_read(rb_addr);
    e.fl   = m_fl;
    e.busy = m_pv;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("ra_out", {16'h0, ra_out}, {16'h0, got.ra});
    chk("rb_out", {16'h0, rb_out}, {16'h0, got.rb});
    chk("flags", {29'h0, flags}, {29'h0, got.fl});
    chk("wb_busy", {31'h0, wb_busy}, {31'h0, got.busy});
    @(posedge clk);
    if (m_pv) m_arr[m_pa] = m_pd;
    m_pv = wr_en && (wr_addr != 3'd0);
    m_pa = wr_addr;
    m_pd = sh_out;
    if (flag_en) m_fl = {(sh_out == 16'h0000), sh_out[15], alu_c};
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 3'd0; sh_out = 16'h0000;
    flag_en = 1'b0; alu_c = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    idle_inputs();
    ra_addr = 3'd1; rb_addr = 3'd2;
    #3;
    chk("rst_ra", {16'h0, ra_out}, 32'h0);
    chk("rst_flags", {29'h0, flags}, 32'h0);
    chk("rst_busy", {31'h0, wb_busy}, 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic write R2 = BEEF
    ra_addr = 3'd2; rb_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; sh_out = 16'hBEEF;
    step();
    idle_inputs();
    step();
    step();
    chk("basic_r2", {16'h0, ra_out}, 32'h0000BEEF);

    // write to R0 with flag update
    wr_en = 1'b1; wr_addr = 3'd0; sh_out = 16'hFFFF; flag_en = 1'b1; alu_c = 1'b0;
    ra_addr = 3'd0;
    step();
    idle_inputs();
    chk("r0_flags", {29'h0, flags}, 32'h2);
    chk("r0_busy", {31'h0, wb_busy}, 32'h0);
    chk("r0_read", {16'h0, ra_out}, 32'h0);
    step();

    // back-to-back same address
    ra_addr = 3'd4; rb_addr = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; sh_out = 16'h0001;
    step();
    sh_out = 16'h0002;
    step();
    idle_inputs();
    step();
    step();
    chk("b2b_ra", {16'h0, ra_out}, 32'h2);
    chk("b2b_rb", {16'h0, rb_out}, 32'h2);

    // flags set then hold
    sh_out = 16'h0000; alu_c = 1'b1; flag_en = 1'b1;
    step();
    chk("flags_set", {29'h0, flags}, 32'h5);
    flag_en = 1'b0; sh_out = 16'h8000; alu_c = 1'b0;
    step();
    chk("flags_hold", {29'h0, flags}, 32'h5);

    // dual read right after write (bypass-dependent, model decides)
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd1; sh_out = 16'h00AA;
    step();
    idle_inputs();
    ra_addr = 3'd1; rb_addr = 3'd1;
    step();
    step();
    chk("dual_ra", {16'h0, ra_out}, 32'h00AA);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      sh_out  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      alu_c   = 1'($urandom_range(0, 1));
      flag_en = 1'($urandom_range(0, 1));
      ra_addr = ($urandom_range(0, 1) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rb_addr = 3'($urandom_range(0, 7));
      step();
    end

    // reset while a write to R5 is pending
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd3; sh_out = 16'h1234;
    step();
    idle_inputs();
    step();
    step();
    ra_addr = 3'd3; rb_addr = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; sh_out = 16'h5555;
    step();
    idle_inputs();
    chk("pre_rst_busy", {31'h0, wb_busy}, 32'h1);
    chk("pre_rst_r3", {16'h0, ra_out}, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ra", {16'h0, ra_out}, 32'h0);
    chk("arst_rb", {16'h0, rb_out}, 32'h0);
    chk("arst_flags", {29'h0, flags}, 32'h0);
    chk("arst_busy", {31'h0, wb_busy}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();
    step();
    chk("r5_never", {16'h0, rb_out}, 32'h0);

    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
